// File: rtl/memory_cycle.sv
// memory_cycle
// Memory-access stage of a five-stage RISC-V pipeline. Issues loads and stores
// on a ready-handshake data-memory port, aligns and extends load data, builds
// store byte enables and replicated store data, stalls upstream stages while the
// memory is busy, and registers the MEM/WB bundle.
//
// Ports:
//   clk, rst                     pipeline clock, asynchronous active-high reset
//   ALUResultM, WriteDataM       effective address, store source data
//   PCPlus4M, InstrM, AuLu_ResultM, RdM, RegWriteM, MemWriteM, ResultSrcM
//                                EX/MEM bundle (InstrM[14:12] is funct3)
//   dmem_req/we/addr/wdata/be    data-memory request side
//   dmem_ready, dmem_rdata       data-memory response side
//   StallM                       hold IF/ID/EX and the EX/MEM register
//   MisalignM, BusErrM           one-cycle exception flags
//   *W                           MEM/WB register outputs
module memory_cycle #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] InstrM,
  input  logic [31:0] AuLu_ResultM,
  input  logic [4:0]  RdM,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrM,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCPlus4W,
  output logic [31:0] InstrW,
  output logic [31:0] AuLu_ResultW,
  output logic [4:0]  RdW,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW
);

  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic [2:0]  funct3;
  logic [1:0]  off;
  logic        is_load;
  logic        acc;
  logic        bad;
  logic        live;
  logic        expired;
  logic        load_done;
  logic        kill;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_ext;

  assign funct3  = InstrM[14:12];
  assign off     = ALUResultM[1:0];
  assign is_load = (ResultSrcM == 2'b01);
  assign acc     = MemWriteM | is_load;

  // Alignment / width legality. Unsupported widths (and unsigned widths on a
  // store) are handled exactly like a misaligned access: no request, bubble.
  always_comb begin
    bad = 1'b0;
    case (funct3)
      3'b000:  bad = 1'b0;
      3'b001:  bad = off[0];
      3'b010:  bad = |off;
      3'b100:  bad = MemWriteM;
      3'b101:  bad = MemWriteM | off[0];
      default: bad = 1'b1;
    endcase
  end

  // live: a legal access sits in M. expired: the wait budget is used up.
  assign live    = ~rst & acc & ~bad;
  assign expired = (state == WAIT) && (cnt == CNT_LIMIT);

  assign dmem_req  = live & ~expired;
  assign dmem_we   = dmem_req & MemWriteM;
  assign dmem_addr = {ALUResultM[31:2], 2'b00};
  assign StallM    = dmem_req & ~dmem_ready;
  assign MisalignM = ~rst & acc & bad;
  // A ready arriving in the expiry cycle still completes the access.
  assign BusErrM   = live & expired & ~dmem_ready;
  assign load_done = live & is_load & ~MemWriteM & dmem_ready;
  assign kill      = MisalignM | BusErrM;

  // Store lane replication and byte enables; loads always read the full word.
  always_comb begin
    dmem_wdata = WriteDataM;
    dmem_be    = 4'b1111;
    if (MemWriteM) begin
      case (funct3[1:0])
        2'b00: begin
          dmem_wdata = {4{WriteDataM[7:0]}};
          dmem_be    = 4'(4'b0001 << off);
        end
        2'b01: begin
          dmem_wdata = {2{WriteDataM[15:0]}};
          dmem_be    = 4'(4'b0011 << off);
        end
        default: begin
          dmem_wdata = WriteDataM;
          dmem_be    = 4'b1111;
        end
      endcase
    end
  end

  // Load alignment and extension.
  always_comb begin
    case (off)
      2'b00:   sel_byte = dmem_rdata[7:0];
      2'b01:   sel_byte = dmem_rdata[15:8];
      2'b10:   sel_byte = dmem_rdata[23:16];
      default: sel_byte = dmem_rdata[31:24];
    endcase
    sel_half = off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3)
      3'b000:  load_ext = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  load_ext = {{16{sel_half[15]}}, sel_half};
      3'b100:  load_ext = {24'd0, sel_byte};
      3'b101:  load_ext = {16'd0, sel_half};
      default: load_ext = dmem_rdata;
    endcase
  end

  // Handshake FSM. cnt counts stalled cycles of the current access, so the
  // access expires after exactly TIMEOUT_CYCLES stall cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (StallM) begin
            state <= WAIT;
            cnt   <= CNT_W'(1);
          end else begin
            cnt <= '0;
          end
        end
        default: begin
          if (!dmem_req || dmem_ready) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  // MEM/WB register: bubble while stalled, otherwise retire the M bundle with
  // the register write suppressed for misaligned or timed-out accesses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || StallM) begin
      ALUResultW   <= '0;
      ReadDataW    <= '0;
      PCPlus4W     <= '0;
      InstrW       <= '0;
      AuLu_ResultW <= '0;
      RdW          <= '0;
      RegWriteW    <= 1'b0;
      ResultSrcW   <= 2'b00;
    end else begin
      ALUResultW   <= ALUResultM;
      ReadDataW    <= load_done ? load_ext : 32'd0;
      PCPlus4W     <= PCPlus4M;
      InstrW       <= InstrM;
      AuLu_ResultW <= AuLu_ResultM;
      RdW          <= kill ? 5'd0 : RdM;
      RegWriteW    <= RegWriteM & ~kill;
      ResultSrcW   <= ResultSrcM;
    end
  end

endmodule

// File: tb/tb_memory_cycle.sv
module tb_memory_cycle;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M, InstrM, AuLu_ResultM;
  logic [4:0]  RdM;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        StallM, MisalignM, BusErrM;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W, InstrW, AuLu_ResultW;
  logic [4:0]  RdW;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  memory_cycle #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
    .InstrM(InstrM), .AuLu_ResultM(AuLu_ResultM), .RdM(RdM),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .StallM(StallM), .MisalignM(MisalignM),
    .BusErrM(BusErrM), .ALUResultW(ALUResultW), .ReadDataW(ReadDataW),
    .PCPlus4W(PCPlus4W), .InstrW(InstrW), .AuLu_ResultW(AuLu_ResultW),
    .RdW(RdW), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input logic [31:0] addr, input logic [2:0] f3, input logic mw,
                       input logic [1:0] rs, input logic rw, input logic [31:0] wd,
                       input logic [31:0] pc);
    ALUResultM   = addr;
    InstrM       = {17'd0, f3, 5'd7, 7'h03};
    MemWriteM    = mw;
    ResultSrcM   = rs;
    RegWriteM    = rw;
    WriteDataM   = wd;
    RdM          = 5'd7;
    PCPlus4M     = pc;
    AuLu_ResultM = 32'hA0A0_0000 | pc;
  endtask

  // Load held with no ready: TO stall cycles, then one BusErrM cycle and a bubble.
  task automatic run_timeout(input string tag, input logic [31:0] pc);
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      chk({tag, "_stall"}, 32'(StallM), 32'd1);
      chk({tag, "_noerr"}, 32'(BusErrM), 32'd0);
      step();
    end
    @(negedge clk);
    chk({tag, "_stall_end"}, 32'(StallM), 32'd0);
    chk({tag, "_req_drop"}, 32'(dmem_req), 32'd0);
    chk({tag, "_buserr"}, 32'(BusErrM), 32'd1);
    step();
    chk({tag, "_w_regwrite"}, 32'(RegWriteW), 32'd0);
    chk({tag, "_w_rd"}, 32'(RdW), 32'd0);
    chk({tag, "_w_pc"}, PCPlus4W, pc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a legal load and ready presented: everything must stay quiet.
    rst = 1'b1;
    dmem_ready = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    set_m(32'h100, 3'b010, 1'b0, 2'b01, 1'b1, 32'd0, 32'h1004);
    #3;
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_stall", 32'(StallM), 32'd0);
    chk("rst_regwrite", 32'(RegWriteW), 32'd0);
    chk("rst_pc", PCPlus4W, 32'd0);
    chk("rst_alu", ALUResultW, 32'd0);
    step();
    rst = 1'b0;

    // lw 0x100, zero wait.
    @(negedge clk);
    chk("lw_req", 32'(dmem_req), 32'd1);
    chk("lw_stall", 32'(StallM), 32'd0);
    chk("lw_addr", dmem_addr, 32'h100);
    chk("lw_be", 32'(dmem_be), 32'hF);
    chk("lw_we", 32'(dmem_we), 32'd0);
    step();
    chk("lw_rdata", ReadDataW, 32'hDEAD_BEEF);
    chk("lw_regwrite", 32'(RegWriteW), 32'd1);
    chk("lw_rd", 32'(RdW), 32'd7);
    chk("lw_src", 32'(ResultSrcW), 32'd1);

    // lb / lbu / lh / lhu, back to back, zero wait.
    dmem_rdata = 32'h80FF_0011;
    set_m(32'h103, 3'b000, 1'b0, 2'b01, 1'b1, 32'd0, 32'h1008);
    step();
    chk("lb_data", ReadDataW, 32'hFFFF_FF80);
    set_m(32'h103, 3'b100, 1'b0, 2'b01, 1'b1, 32'd0, 32'h100C);
    step();
    chk("lbu_data", ReadDataW, 32'h0000_0080);
    chk("lbu_instr", InstrW, {17'd0, 3'b100, 5'd7, 7'h03});
    set_m(32'h102, 3'b001, 1'b0, 2'b01, 1'b1, 32'd0, 32'h1010);
    step();
    chk("lh_data", ReadDataW, 32'hFFFF_80FF);
    set_m(32'h100, 3'b101, 1'b0, 2'b01, 1'b1, 32'd0, 32'h1014);
    step();
    chk("lhu_data", ReadDataW, 32'h0000_0011);

    // sb 0x201, zero wait.
    set_m(32'h201, 3'b000, 1'b1, 2'b00, 1'b0, 32'h0000_005A, 32'h1018);
    @(negedge clk);
    chk("sb_be", 32'(dmem_be), 32'h2);
    chk("sb_wdata", dmem_wdata, 32'h5A5A_5A5A);
    chk("sb_we", 32'(dmem_we), 32'd1);
    step();

    // sh 0x202, ready after 3 stall cycles.
    dmem_ready = 1'b0;
    set_m(32'h202, 3'b001, 1'b1, 2'b00, 1'b0, 32'h1234_ABCD, 32'h2004);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("sh_stall", 32'(StallM), 32'd1);
      chk("sh_be", 32'(dmem_be), 32'hC);
      chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
      chk("sh_addr", dmem_addr, 32'h200);
      chk("sh_we", 32'(dmem_we), 32'd1);
      step();
      chk("sh_bubble_pc", PCPlus4W, 32'd0);
      chk("sh_bubble_src", 32'(ResultSrcW), 32'd0);
    end
    dmem_ready = 1'b1;
    @(negedge clk);
    chk("sh_stall_end", 32'(StallM), 32'd0);
    chk("sh_req_held", 32'(dmem_req), 32'd1);
    step();
    chk("sh_retire_pc", PCPlus4W, 32'h2004);
    chk("sh_retire_regwrite", 32'(RegWriteW), 32'd0);

    // Misaligned lw 0x101.
    dmem_ready = 1'b0;
    set_m(32'h101, 3'b010, 1'b0, 2'b01, 1'b1, 32'd0, 32'h3004);
    @(negedge clk);
    chk("mis_req", 32'(dmem_req), 32'd0);
    chk("mis_flag", 32'(MisalignM), 32'd1);
    chk("mis_stall", 32'(StallM), 32'd0);
    step();
    chk("mis_regwrite", 32'(RegWriteW), 32'd0);
    chk("mis_rd", 32'(RdW), 32'd0);
    chk("mis_pc", PCPlus4W, 32'h3004);
    set_m(32'h55, 3'b000, 1'b0, 2'b00, 1'b1, 32'd0, 32'h3008);
    @(negedge clk);
    chk("alu_misflag", 32'(MisalignM), 32'd0);
    chk("alu_req", 32'(dmem_req), 32'd0);
    step();
    chk("alu_result", ALUResultW, 32'h55);
    chk("alu_regwrite", 32'(RegWriteW), 32'd1);
    chk("alu_rd", 32'(RdW), 32'd7);
    chk("alu_aulu", AuLu_ResultW, 32'hA0A0_3008);

    // Timeout with ready never asserted.
    set_m(32'h300, 3'b010, 1'b0, 2'b01, 1'b1, 32'd0, 32'h4004);
    run_timeout("to1", 32'h4004);
    set_m(32'h55, 3'b000, 1'b0, 2'b00, 1'b1, 32'd0, 32'h4008);
    @(negedge clk);
    chk("to1_err_clear", 32'(BusErrM), 32'd0);
    step();

    // Ready arriving in the expiry cycle wins.
    dmem_rdata = 32'h1122_3344;
    set_m(32'h300, 3'b010, 1'b0, 2'b01, 1'b1, 32'd0, 32'h5004);
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      chk("rw_stall", 32'(StallM), 32'd1);
      step();
    end
    dmem_ready = 1'b1;
    @(negedge clk);
    chk("rw_noerr", 32'(BusErrM), 32'd0);
    chk("rw_stall_end", 32'(StallM), 32'd0);
    step();
    chk("rw_regwrite", 32'(RegWriteW), 32'd1);
    chk("rw_data", ReadDataW, 32'h1122_3344);
    dmem_ready = 1'b0;

    // Reset during WAIT cycle 2, then a full timeout proves FSM/counter cleared.
    set_m(32'h300, 3'b010, 1'b0, 2'b01, 1'b1, 32'd0, 32'h6004);
    @(negedge clk);
    chk("rw2_stall1", 32'(StallM), 32'd1);
    step();
    rst = 1'b1;
    #1;
    chk("rstw_req", 32'(dmem_req), 32'd0);
    chk("rstw_stall", 32'(StallM), 32'd0);
    chk("rstw_buserr", 32'(BusErrM), 32'd0);
    chk("rstw_regwrite", 32'(RegWriteW), 32'd0);
    step();
    rst = 1'b0;
    run_timeout("to2", 32'h6004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
